pipelined_decode_unit: RTL and testbench

- Registered, handshaked decode stage for the pipelined core. It generalises the combinational decoder in three ways: a configurable PC register index and ALU-control width, ARM-style conditional execution against an internal NZCV flag register, and a pending-flag-writer scoreboard.
- Sits between fetch and execute.
- Stalls conditional instructions while an older flag-setting instruction is still in flight.

---
 rtl/pipelined_decode_unit_if.sv | 51 +++++
 rtl/pipelined_decode_unit.sv | 160 ++++++++++++++++
 tb/tb_pipelined_decode_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_decode_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_decode_unit_if
// Brief    : Fetch-side / execute-side handshake bundle for the decode stage.
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_decode_unit_if #(
    parameter int RA_W  = 4,
    parameter int ALU_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [3:0]       funct;
    logic [RA_W-1:0]  rd;
    logic [3:0]       cond;
    logic             flags_we;
    logic [3:0]       flags_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             pc_src;
    logic             reg_write;
    logic             mem_write;
    logic             mem_reg;
    logic             alu_src;
    logic             no_write;
    logic             mov_src;
    logic             reg_src;
    logic             flag_write;
    logic             branch_taken;
    logic [ALU_W-1:0] alu_control;
    logic [1:0]       imm_src;
    logic             cond_pass;
    logic [3:0]       flags_q;

    modport master (
        output in_valid, op, funct, rd, cond, flags_we, flags_in, flush, out_ready,
        input  in_ready, out_valid, pc_src, reg_write, mem_write, mem_reg, alu_src,
               no_write, mov_src, reg_src, flag_write, branch_taken, alu_control,
               imm_src, cond_pass, flags_q
    );

    modport slave (
        input  in_valid, op, funct, rd, cond, flags_we, flags_in, flush, out_ready,
        output in_ready, out_valid, pc_src, reg_write, mem_write, mem_reg, alu_src,
               no_write, mov_src, reg_src, flag_write, branch_taken, alu_control,
               imm_src, cond_pass, flags_q
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_decode_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_decode_unit
// Brief    : Registered decode stage with conditional execution and a
//            pending-flag-writer scoreboard that stalls conditional issue.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_decode_unit #(
    parameter int RA_W   = 4,
    parameter int PC_REG = 11,
    parameter int ALU_W  = 2,
    parameter int CNT_W  = 3
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    pipelined_decode_unit_if.slave bus
);

    localparam logic [3:0]       C_COND_AL  = 4'b1110;
    localparam logic [CNT_W-1:0] C_PEND_MAX = '1;

    typedef struct packed {
        logic             pc_src;
        logic             reg_write;
        logic             mem_write;
        logic             mem_reg;
        logic             alu_src;
        logic             no_write;
        logic             mov_src;
        logic             reg_src;
        logic             flag_write;
        logic             branch_taken;
        logic [ALU_W-1:0] alu_control;
        logic [1:0]       imm_src;
        logic             cond_pass;
    } bundle_t;

    bundle_t          bundle_d,    bundle_q;
    logic             out_valid_d, out_valid_q;
    logic [3:0]       nzcv_d,      nzcv_q;
    logic [CNT_W-1:0] pending_d,   pending_q;

    logic    w_dp, w_mem, w_br, w_pass, w_stall, w_ready, w_accept, w_inc;
    bundle_t w_bundle;

    assign w_dp  = (bus.op == 2'b00);
    assign w_mem = (bus.op == 2'b01);
    assign w_br  = (bus.op == 2'b10);

    // Condition uses the flag value before any same-cycle writeback.
    always_comb begin
        w_pass = 1'b0;
        case (bus.cond)
            4'b0000: w_pass = nzcv_q[2];
            4'b0001: w_pass = ~nzcv_q[2];
            4'b0010: w_pass = nzcv_q[1];
            4'b0011: w_pass = ~nzcv_q[1];
            4'b0100: w_pass = nzcv_q[3];
            4'b0101: w_pass = ~nzcv_q[3];
            4'b0110: w_pass = nzcv_q[0];
            4'b0111: w_pass = ~nzcv_q[0];
            4'b1000: w_pass = nzcv_q[1] & ~nzcv_q[2];
            4'b1001: w_pass = ~nzcv_q[1] | nzcv_q[2];
            4'b1010: w_pass = (nzcv_q[3] == nzcv_q[0]);
            4'b1011: w_pass = (nzcv_q[3] != nzcv_q[0]);
            4'b1100: w_pass = ~nzcv_q[2] & (nzcv_q[3] == nzcv_q[0]);
            4'b1101: w_pass = nzcv_q[2] | (nzcv_q[3] != nzcv_q[0]);
            4'b1110: w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    always_comb begin
        w_bundle              = '0;
        w_bundle.mem_reg      = w_mem & bus.funct[1];
        w_bundle.mem_write    = w_mem & ~bus.funct[1];
        w_bundle.alu_src      = ((w_mem | w_dp) & bus.funct[0]) | w_br;
        w_bundle.reg_write    = w_dp | w_bundle.mem_reg;
        w_bundle.pc_src       = w_br | ((bus.rd == RA_W'(PC_REG)) & w_bundle.reg_write);
        w_bundle.flag_write   = w_dp & bus.funct[1];
        w_bundle.no_write     = w_dp & ~bus.funct[3] & bus.funct[2];
        w_bundle.mov_src      = w_dp & bus.funct[3] & bus.funct[2] & bus.funct[0];
        w_bundle.alu_control  = (w_dp & ~w_bundle.mov_src) ? ALU_W'(bus.funct[3:2]) : '0;
        w_bundle.branch_taken = w_br;
        w_bundle.reg_src      = w_br;
        w_bundle.imm_src      = bus.op;
        w_bundle.cond_pass    = w_pass;
        if (!w_pass) begin
            w_bundle.pc_src       = 1'b0;
            w_bundle.reg_write    = 1'b0;
            w_bundle.mem_write    = 1'b0;
            w_bundle.mem_reg      = 1'b0;
            w_bundle.flag_write   = 1'b0;
            w_bundle.branch_taken = 1'b0;
        end
    end

    assign w_stall  = bus.in_valid &
                      ((((pending_q != '0) | bus.flags_we) & (bus.cond != C_COND_AL)) |
                       (w_dp & bus.funct[1] & (pending_q == C_PEND_MAX)));
    assign w_ready  = ~w_stall & ~bus.flush & (~out_valid_q | bus.out_ready);
    assign w_accept = bus.in_valid & w_ready;
    assign w_inc    = out_valid_q & bus.out_ready & bundle_q.flag_write;

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        nzcv_d      = bus.flags_we ? bus.flags_in : nzcv_q;
        pending_d   = pending_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
            bundle_d    = w_bundle;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        // Counter saturates rather than wrapping if an in-register writer slips past the stall.
        if (bus.flush) begin
            pending_d = '0;
        end else if (w_inc && !bus.flags_we) begin
            if (pending_q != C_PEND_MAX) pending_d = pending_q + 1'b1;
        end else if (!w_inc && bus.flags_we) begin
            if (pending_q != '0) pending_d = pending_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            nzcv_q      <= '0;
            pending_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            nzcv_q      <= nzcv_d;
            pending_q   <= pending_d;
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.pc_src       = bundle_q.pc_src;
    assign bus.reg_write    = bundle_q.reg_write;
    assign bus.mem_write    = bundle_q.mem_write;
    assign bus.mem_reg      = bundle_q.mem_reg;
    assign bus.alu_src      = bundle_q.alu_src;
    assign bus.no_write     = bundle_q.no_write;
    assign bus.mov_src      = bundle_q.mov_src;
    assign bus.reg_src      = bundle_q.reg_src;
    assign bus.flag_write   = bundle_q.flag_write;
    assign bus.branch_taken = bundle_q.branch_taken;
    assign bus.alu_control  = bundle_q.alu_control;
    assign bus.imm_src      = bundle_q.imm_src;
    assign bus.cond_pass    = bundle_q.cond_pass;
    assign bus.flags_q      = nzcv_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_decode_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_decode_unit
// Brief    : Scoreboard bench for pipelined_decode_unit (one-deep flag counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_decode_unit;

    localparam logic [3:0] AL = 4'b1110;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   w;
    logic [3:0]  m_flags = 4'b0000;
    logic [14:0] sb[$];
    logic [14:0] exp_a;

    pipelined_decode_unit_if #(.RA_W(4), .ALU_W(2)) bus ();

    pipelined_decode_unit #(.RA_W(4), .PC_REG(11), .ALU_W(2), .CNT_W(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: {pc,rw,mw,mr,as,nw,ms,rs,fw,bt,alu[1:0],imm[1:0],pass}
    function automatic logic [14:0] model(input logic [1:0] op, input logic [3:0] f,
                                          input logic [3:0] rd, input logic [3:0] c,
                                          input logic [3:0] fl);
        logic n, z, cf, v, pass;
        logic pc, rw, mw, mr, as, nw, ms, rs, fw, bt;
        logic [1:0] ac;
        {n, z, cf, v} = fl;
        case (c)
            4'h0: pass = z;          4'h1: pass = !z;
            4'h2: pass = cf;         4'h3: pass = !cf;
            4'h4: pass = n;          4'h5: pass = !n;
            4'h6: pass = v;          4'h7: pass = !v;
            4'h8: pass = cf && !z;   4'h9: pass = !cf || z;
            4'hA: pass = (n == v);   4'hB: pass = (n != v);
            4'hC: pass = !z && (n == v);
            4'hD: pass = z || (n != v);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        {pc, rw, mw, mr, as, nw, ms, rs, fw, bt} = '0;
        ac = 2'b00;
        case (op)
            2'b00: begin
                rw = 1'b1; as = f[0]; fw = f[1];
                nw = (f[3:2] == 2'b01);
                ms = (f[3:2] == 2'b11) && f[0];
                ac = ms ? 2'b00 : f[3:2];
                pc = (rd == 4'd11);
            end
            2'b01: begin
                mr = f[1]; mw = !f[1]; rw = f[1]; as = f[0];
                pc = f[1] && (rd == 4'd11);
            end
            2'b10: begin
                as = 1'b1; pc = 1'b1; bt = 1'b1; rs = 1'b1;
            end
            default: ;
        endcase
        if (!pass) {pc, rw, mw, mr, fw, bt} = '0;
        return {pc, rw, mw, mr, as, nw, ms, rs, fw, bt, ac, op, pass};
    endfunction

    function automatic logic [14:0] observed();
        return {bus.pc_src, bus.reg_write, bus.mem_write, bus.mem_reg, bus.alu_src,
                bus.no_write, bus.mov_src, bus.reg_src, bus.flag_write, bus.branch_taken,
                bus.alu_control, bus.imm_src, bus.cond_pass};
    endfunction

    task automatic drive(input logic [1:0] op, input logic [3:0] f, input logic [3:0] rd,
                         input logic [3:0] c);
        bus.in_valid = 1'b1; bus.op = op; bus.funct = f; bus.rd = rd; bus.cond = c;
    endtask

    // Waits (bounded) for the presented instruction to be taken, then drops in_valid.
    task automatic wait_accept(input int max_cyc, output int waited);
        for (waited = 0; waited < max_cyc; waited++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (waited == max_cyc) begin
            check_val("accept_timeout", {31'd0, bus.in_ready}, 1);
        end else begin
            sb.push_back(model(bus.op, bus.funct, bus.rd, bus.cond, m_flags));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] f, input logic [3:0] rd,
                        input logic [3:0] c, output int waited);
        @(posedge clk); #1;
        drive(op, f, rd, c);
        wait_accept(8, waited);
    endtask

    task automatic pulse_flags(input logic [3:0] v, input logic exp_ready);
        @(posedge clk); #1;
        bus.flags_we = 1'b1; bus.flags_in = v;
        @(negedge clk);
        check_val("ready_during_we", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        @(posedge clk);
        m_flags = v;
        #1 bus.flags_we = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) check_val("unexpected_issue", {17'd0, observed()}, 0);
            else                check_val("issue_bundle", {17'd0, observed()}, {17'd0, sb.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.op = 2'b00; bus.funct = 4'h0; bus.rd = 4'h0; bus.cond = AL;
        bus.flags_we = 1'b0; bus.flags_in = 4'h0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        #12;
        check_val("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check_val("rst_bundle", {17'd0, observed()}, 0);
        check_val("rst_flags", {28'd0, bus.flags_q}, 0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_in_ready", {31'd0, bus.in_ready}, 1);

        // Data-processing flag writer
        send(2'b00, 4'b0110, 4'd3, AL, w);
        @(negedge clk);
        check_val("dp_out_valid", {31'd0, bus.out_valid}, 1);
        check_val("dp_ctrl", {28'd0, bus.reg_write, bus.flag_write, bus.no_write, bus.pc_src}, 4'b1110);
        check_val("dp_alu", {30'd0, bus.alu_control}, 2'b01);
        check_val("dp_pass", {31'd0, bus.cond_pass}, 1);

        // PC write, load, move, branch, reserved
        send(2'b00, 4'b1000, 4'd11, AL, w);
        @(negedge clk);
        check_val("pcw", {29'd0, bus.pc_src, bus.alu_control}, 3'b110);
        send(2'b01, 4'b0010, 4'd5, AL, w);
        @(negedge clk);
        check_val("load", {29'd0, bus.mem_reg, bus.reg_write, bus.mem_write}, 3'b110);
        send(2'b00, 4'b1101, 4'd1, AL, w);
        @(negedge clk);
        check_val("mov", {29'd0, bus.mov_src, bus.alu_control}, 3'b100);
        send(2'b10, 4'b0000, 4'd0, AL, w);
        send(2'b11, 4'b1111, 4'd11, AL, w);

        // Conditional execution on Z=1
        pulse_flags(4'b0100, 1'b1);
        send(2'b00, 4'b0000, 4'd2, 4'b0000, w);
        @(negedge clk);
        check_val("eq_pass", {31'd0, bus.cond_pass}, 1);
        send(2'b00, 4'b0000, 4'd2, 4'b0001, w);
        @(negedge clk);
        check_val("ne_fail", {29'd0, bus.out_valid, bus.reg_write, bus.cond_pass}, 3'b100);
        send(2'b10, 4'b0000, 4'd0, 4'b1100, w);
        send(2'b01, 4'b0001, 4'd4, 4'b1001, w);

        // Scoreboard stall on a pending flag writer
        send(2'b00, 4'b0010, 4'd6, AL, w);
        @(posedge clk); #1;
        drive(2'b00, 4'b0000, 4'd7, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("eq_stall", {31'd0, bus.in_ready}, 0);
            @(posedge clk); #1;
        end
        drive(2'b00, 4'b0000, 4'd8, AL);
        wait_accept(8, w);
        check_val("al_in_window", w, 0);
        drive(2'b00, 4'b0000, 4'd7, 4'b0000);
        pulse_flags(4'b0100, 1'b0);
        wait_accept(8, w);
        check_val("eq_release", w, 0);

        // Saturated counter blocks a second flag writer
        send(2'b00, 4'b0010, 4'd9, AL, w);
        @(posedge clk); #1;
        drive(2'b00, 4'b0010, 4'd10, AL);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("sat_stall", {31'd0, bus.in_ready}, 0);
            @(posedge clk); #1;
        end
        pulse_flags(4'b0100, 1'b0);
        wait_accept(8, w);
        check_val("sat_release", w, 0);

        // Backpressure
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(2'b00, 4'b0001, 4'd4, AL, w);
        exp_a = model(2'b00, 4'b0001, 4'd4, AL, m_flags);
        drive(2'b01, 4'b0011, 4'd5, AL);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("bp_hold", {15'd0, bus.out_valid, bus.in_ready, observed()},
                      {15'd0, 1'b1, 1'b0, exp_a});
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        wait_accept(8, w);
        check_val("bp_release", w, 0);
        @(negedge clk);
        check_val("bp_next_valid", {31'd0, bus.out_valid}, 1);

        // Flush kills the bundle, blocks accept and clears the counter
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(2'b00, 4'b0000, 4'd12, AL, w);
        drive(2'b01, 4'b0000, 4'd13, AL);
        bus.flush = 1'b1;
        @(negedge clk);
        check_val("flush_no_accept", {31'd0, bus.in_ready}, 0);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        check_val("flush_kill", {31'd0, bus.out_valid}, 0);
        if (sb.size() != 0) void'(sb.pop_back());
        drive(2'b00, 4'b0001, 4'd14, 4'b0000);
        wait_accept(8, w);
        check_val("flush_clears_pending", w, 0);

        // Asynchronous reset in the middle of a stall
        @(posedge clk); #1;
        send(2'b00, 4'b0010, 4'd6, AL, w);
        @(posedge clk); #1;
        drive(2'b00, 4'b0000, 4'd7, 4'b0000);
        @(negedge clk);
        check_val("pre_rst_stall", {31'd0, bus.in_ready}, 0);
        #2 rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_val("arst_out_valid", {31'd0, bus.out_valid}, 0);
        check_val("arst_bundle", {17'd0, observed()}, 0);
        check_val("arst_flags", {28'd0, bus.flags_q}, 0);
        sb.delete();
        m_flags = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_idle", {31'd0, bus.out_valid}, 0);
        check_val("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
